// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder.
//   dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES   : bytes per memory word
//   dmem_req_t   : latched request fields {rd, wr, addr, wdata}
package mips_mem_pkg;

   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter timing the wait states of a memory transaction.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one, saturating at zero
//   expire_o   : count is 1, i.e. this is the last wait cycle
module wait_counter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             expire_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == Width'(1));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with a valid/ready request channel, a configurable number of
// wait states and a one-cycle response pulse. Owns the word-addressed storage array.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : request present          req_ready  : request can be accepted (IDLE)
//   MemRead    : load                     MemWrite   : store
//   address    : byte address             write_data : store data
//   resp_valid : one-cycle response pulse
//   read_data  : load result (0 on store or error), held until the next response
//   resp_err   : misaligned, out-of-range or malformed (rd == wr) request
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic        resp_valid,
   output logic [31:0] read_data,
   output logic        resp_err
);

   localparam int unsigned OffW = $clog2(WORD_BYTES);
   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned CntW = 4;

   dmem_state_t     state_q, state_d;
   dmem_req_t       req_q, req_d;
   logic            accept, enter_resp;
   logic            cnt_load, cnt_dec, cnt_expire;
   logic            req_err;
   logic [IdxW-1:0] word_idx;
   logic [31:0]     mem_q [DEPTH];
   logic [31:0]     read_data_q;
   logic            resp_err_q;

   wait_counter #(
      .Width(CntW)
   ) u_wait_counter (
      .clk       (clk),
      .rst       (rst),
      .load_i    (cnt_load),
      .load_val_i(CntW'(LATENCY)),
      .dec_i     (cnt_dec),
      .expire_o  (cnt_expire)
   );

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      enter_resp = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept   = 1'b1;
               cnt_load = 1'b1;
               if (LATENCY == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_expire) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // With zero latency the access happens on the accepting edge, so the array is always
   // addressed through the next-state copy of the request.
   always_comb begin
      req_d = req_q;
      if (accept) begin
         req_d.rd    = MemRead;
         req_d.wr    = MemWrite;
         req_d.addr  = address;
         req_d.wdata = write_data;
      end
   end

   assign word_idx = req_d.addr[IdxW+OffW-1:OffW];
   assign req_err  = (req_d.addr[OffW-1:0] != '0) ||
                     (req_d.addr[31:IdxW+OffW] != '0) ||
                     (req_d.rd == req_d.wr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         req_q       <= '0;
         read_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         if (enter_resp) begin
            resp_err_q  <= req_err;
            read_data_q <= (req_err || !req_d.rd) ? '0 : mem_q[word_idx];
         end
      end
   end

   // Contents are not reset; a reset on the committing edge drops the store.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && req_d.wr && !req_err) begin
         mem_q[word_idx] <= req_d.wdata;
      end
   end

   assign read_data = read_data_q;
   assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int unsigned LAT_A = 2;

   logic        clk;
   logic        rst;
   int          checks;
   int          errors;

   logic        a_valid, a_ready, a_rd, a_wr, a_resp_valid, a_resp_err;
   logic [31:0] a_addr, a_wdata, a_read_data;
   logic        b_valid, b_ready, b_rd, b_wr, b_resp_valid, b_resp_err;
   logic [31:0] b_addr, b_wdata, b_read_data;

   dmem_responder #(
      .DEPTH  (256),
      .LATENCY(LAT_A)
   ) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .req_valid (a_valid),
      .req_ready (a_ready),
      .MemRead   (a_rd),
      .MemWrite  (a_wr),
      .address   (a_addr),
      .write_data(a_wdata),
      .resp_valid(a_resp_valid),
      .read_data (a_read_data),
      .resp_err  (a_resp_err)
   );

   dmem_responder #(
      .DEPTH  (16),
      .LATENCY(0)
   ) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .req_valid (b_valid),
      .req_ready (b_ready),
      .MemRead   (b_rd),
      .MemWrite  (b_wr),
      .address   (b_addr),
      .write_data(b_wdata),
      .resp_valid(b_resp_valid),
      .read_data (b_read_data),
      .resp_err  (b_resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full LATENCY=2 transaction; request inputs are scrambled after the accepting edge.
   task automatic a_txn(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic chk_rdata);
      a_valid = 1'b1;
      a_rd    = rd;
      a_wr    = wr;
      a_addr  = addr;
      a_wdata = wdata;
      chk1({tag, ":ready_before"}, a_ready, 1'b1);
      tick();
      a_valid = 1'b0;
      a_rd    = 1'($urandom);
      a_wr    = 1'($urandom);
      a_addr  = $urandom;
      a_wdata = $urandom;
      for (int i = 0; i < LAT_A; i++) begin
         chk1({tag, ":wait_resp"}, a_resp_valid, 1'b0);
         chk1({tag, ":wait_ready"}, a_ready, 1'b0);
         tick();
      end
      chk1({tag, ":resp_valid"}, a_resp_valid, 1'b1);
      chk1({tag, ":resp_ready"}, a_ready, 1'b0);
      chk1({tag, ":resp_err"}, a_resp_err, exp_err);
      if (chk_rdata) chk32({tag, ":read_data"}, a_read_data, exp_rdata);
      tick();
      chk1({tag, ":after_ready"}, a_ready, 1'b1);
      chk1({tag, ":after_resp"}, a_resp_valid, 1'b0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      a_valid = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
      b_valid = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;

      // Reset values
      tick();
      chk1("rst_a_ready", a_ready, 1'b1);
      chk1("rst_a_resp", a_resp_valid, 1'b0);
      chk32("rst_a_rdata", a_read_data, 32'h0);
      chk1("rst_a_err", a_resp_err, 1'b0);
      chk1("rst_b_ready", b_ready, 1'b1);
      chk1("rst_b_resp", b_resp_valid, 1'b0);

      // Reset and req_valid together: request must not be accepted
      a_valid = 1'b1; a_wr = 1'b1; a_addr = 32'h0; a_wdata = 32'hFFFF_FFFF;
      tick();
      rst = 1'b0; a_valid = 1'b0; a_wr = 1'b0;
      chk1("rst_valid_ready", a_ready, 1'b1);
      tick();
      chk1("rst_valid_ready2", a_ready, 1'b1);
      chk1("rst_valid_resp", a_resp_valid, 1'b0);

      // Known array contents
      a_txn("init0", 1'b0, 1'b1, 32'h0, 32'h1111_1111, 32'h0, 1'b0, 1'b0);
      a_txn("init20", 1'b0, 1'b1, 32'h20, 32'hAAAA_5555, 32'h0, 1'b0, 1'b0);

      // Store then load, load-after-store
      a_txn("st10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      a_txn("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      tick();
      tick();
      chk32("hold_rdata", a_read_data, 32'hDEAD_BEEF);

      // Address errors
      a_txn("ld_mis13", 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
      a_txn("st_oor400", 1'b0, 1'b1, 32'h400, 32'h0000_0BAD, 32'h0, 1'b1, 1'b1);
      a_txn("ld0_clean", 1'b1, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0, 1'b1);

      // Malformed MemRead/MemWrite combinations
      a_txn("both1", 1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b1);
      a_txn("both0", 1'b0, 1'b0, 32'h10, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b1);
      a_txn("ld10_clean", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

      // Reset during WAIT drops the pending store
      a_valid = 1'b1; a_rd = 1'b0; a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678;
      tick();
      a_valid = 1'b0;
      chk1("rstw_in_wait", a_ready, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("rstw_ready", a_ready, 1'b1);
      chk1("rstw_resp", a_resp_valid, 1'b0);
      tick();
      chk1("rstw_resp2", a_resp_valid, 1'b0);
      a_txn("ld20_old", 1'b1, 1'b0, 32'h20, 32'h0, 32'hAAAA_5555, 1'b0, 1'b1);

      // Reset in the RESP cycle: store already committed, pulse still visible
      a_valid = 1'b1; a_rd = 1'b0; a_wr = 1'b1; a_addr = 32'h30; a_wdata = 32'hCAFE_F00D;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      chk1("rstr_resp", a_resp_valid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("rstr_ready", a_ready, 1'b1);
      chk1("rstr_resp_off", a_resp_valid, 1'b0);
      a_txn("ld30", 1'b1, 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);

      // LATENCY=0 with req_valid held high: one request per two cycles
      b_valid = 1'b1; b_rd = 1'b0; b_wr = 1'b1; b_addr = 32'h8; b_wdata = 32'h0102_0304;
      chk1("b_st_ready", b_ready, 1'b1);
      tick();
      b_rd = 1'b1; b_wr = 1'b0; b_wdata = 32'h0;
      chk1("b_st_resp", b_resp_valid, 1'b1);
      chk1("b_st_err", b_resp_err, 1'b0);
      chk1("b_st_busy", b_ready, 1'b0);
      tick();
      chk1("b_idle_ready", b_ready, 1'b1);
      chk1("b_idle_resp", b_resp_valid, 1'b0);
      tick();
      chk1("b_ld_resp", b_resp_valid, 1'b1);
      chk32("b_ld_rdata", b_read_data, 32'h0102_0304);
      chk1("b_ld_busy", b_ready, 1'b0);
      b_addr = 32'h40;
      tick();
      chk1("b_idle2_ready", b_ready, 1'b1);
      tick();
      b_valid = 1'b0;
      chk1("b_oor_resp", b_resp_valid, 1'b1);
      chk1("b_oor_err", b_resp_err, 1'b1);
      chk32("b_oor_rdata", b_read_data, 32'h0);
      tick();
      chk1("b_end_ready", b_ready, 1'b1);
      chk1("b_end_resp", b_resp_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
